// File: rtl/fp_accumulator.sv
// fp_accumulator
// Sequential binary32 accumulator fed by the multiplier in the neuron
// datapath. Each accepted operand is added to the running total ACC with a
// fixed ALIGN -> ADD -> NORM sequence (truncating, denormals flushed to zero).
// When the operand marked LAST has been added, the total and its sticky
// flags are presented in HOLD until the consumer takes them.
//
// Ports
//   CLK           clock, rising edge
//   RESET         asynchronous active-low reset
//   IN_VALID      operand presented
//   IN_READY      operand can be accepted (IDLE only)
//   IN_OPERAND    binary32 operand
//   IN_EXCEPTION  upstream exception for this operand
//   IN_LAST       operand is the final term of the sum
//   OUT_VALID     SUM and flags valid (HOLD only)
//   OUT_READY     consumer takes the result
//   SUM           accumulated total (always equals ACC)
//   EXCEPTION / OVERFLOW / UNDERFLOW  sticky flags for the current sum
module fp_accumulator (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_OPERAND,
    input  logic        IN_EXCEPTION,
    input  logic        IN_LAST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] SUM,
    output logic        EXCEPTION,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam logic [31:0] ACC_ZERO = 32'h0000_0000;
    localparam logic [31:0] ACC_NAN  = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Leading-zero count of a 24-bit magnitude; 24 when the value is zero.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < 24; i++) begin
            if (v[i]) begin
                n = 5'(23 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] op_r;
    logic        op_exc_r, last_r;
    logic [31:0] acc_r, acc_nxt_s;
    logic        exc_r, ovf_r, unf_r;
    logic        exc_nxt_s, ovf_nxt_s, unf_nxt_s;
    logic        in_ready_r, out_valid_r;

    // Alignment stage
    logic [7:0]  a_exp_s, o_exp_s, big_exp_s, small_exp_s, exp_diff_s;
    logic [23:0] a_man_s, o_man_s, big_man_s, small_man_s, small_al_s;
    logic        big_sign_s;
    logic        big_sign_r, eff_sub_r;
    logic [7:0]  big_exp_r;
    logic [23:0] big_man_r, small_al_r;

    // Add stage
    logic [24:0] sum_s, sum_r;
    logic        res_sign_r;
    logic [7:0]  res_exp_r;

    // Normalise stage
    logic [4:0]        lz_s;
    logic signed [9:0] norm_exp_s;
    logic [22:0]       norm_frac_s;
    logic [31:0]       add_res_s;
    logic              add_ovf_s, add_unf_s;

    assign IN_READY  = in_ready_r;
    assign OUT_VALID = out_valid_r;
    assign SUM       = acc_r;
    assign EXCEPTION = exc_r;
    assign OVERFLOW  = ovf_r;
    assign UNDERFLOW = unf_r;

    // Unpack ACC and operand, pick the larger magnitude, align the smaller.
    always_comb begin
        a_exp_s     = acc_r[30:23];
        o_exp_s     = op_r[30:23];
        a_man_s     = (a_exp_s == 8'd0) ? 24'd0 : {1'b1, acc_r[22:0]};
        o_man_s     = (o_exp_s == 8'd0) ? 24'd0 : {1'b1, op_r[22:0]};
        big_sign_s  = acc_r[31];
        big_exp_s   = a_exp_s;
        big_man_s   = a_man_s;
        small_exp_s = o_exp_s;
        small_man_s = o_man_s;
        if ({a_exp_s, a_man_s} < {o_exp_s, o_man_s}) begin
            big_sign_s  = op_r[31];
            big_exp_s   = o_exp_s;
            big_man_s   = o_man_s;
            small_exp_s = a_exp_s;
            small_man_s = a_man_s;
        end else begin
            big_sign_s  = acc_r[31];
        end
        exp_diff_s = big_exp_s - small_exp_s;
        if (exp_diff_s >= 8'd25) begin
            small_al_s = 24'd0;
        end else begin
            small_al_s = small_man_s >> exp_diff_s;
        end
    end

    // Magnitude add or subtract; the larger operand is always the minuend.
    always_comb begin
        sum_s = 25'd0;
        if (eff_sub_r) begin
            sum_s = {1'b0, big_man_r} - {1'b0, small_al_r};
        end else begin
            sum_s = {1'b0, big_man_r} + {1'b0, small_al_r};
        end
    end

    // Normalise, truncate and range-check the raw sum.
    always_comb begin
        lz_s        = lzc24(sum_r[23:0]);
        norm_exp_s  = 10'sd0;
        norm_frac_s = 23'd0;
        add_res_s   = ACC_ZERO;
        add_ovf_s   = 1'b0;
        add_unf_s   = 1'b0;
        if (sum_r[24]) begin
            norm_exp_s  = $signed({2'b00, res_exp_r}) + 10'sd1;
            norm_frac_s = sum_r[23:1];
        end else begin
            norm_exp_s  = $signed({2'b00, res_exp_r}) - $signed({5'b00000, lz_s});
            norm_frac_s = 23'(sum_r[23:0] << lz_s);
        end
        if (sum_r == 25'd0) begin
            add_res_s = ACC_ZERO;
        end else if (norm_exp_s >= 10'sd255) begin
            add_ovf_s = 1'b1;
            add_res_s = {res_sign_r, 8'hFF, 23'd0};
        end else if (norm_exp_s <= 10'sd0) begin
            add_unf_s = 1'b1;
            add_res_s = ACC_ZERO;
        end else begin
            add_res_s = {res_sign_r, norm_exp_s[7:0], norm_frac_s};
        end
    end

    // Next-state logic plus the ACC/flag update at NORM and on consumption.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        exc_nxt_s   = exc_r;
        ovf_nxt_s   = ovf_r;
        unf_nxt_s   = unf_r;
        case (state_r)
            ST_IDLE: begin
                if (IN_VALID && in_ready_r) begin
                    state_nxt_s = ST_ALIGN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: state_nxt_s = ST_ADD;
            ST_ADD:   state_nxt_s = ST_NORM;
            ST_NORM: begin
                state_nxt_s = last_r ? ST_HOLD : ST_IDLE;
                // A poisoned sum stays NaN; a saturated sum ignores finite terms.
                if (op_exc_r || (op_r[30:23] == 8'hFF) || exc_r) begin
                    exc_nxt_s = 1'b1;
                    acc_nxt_s = ACC_NAN;
                end else if (ovf_r) begin
                    acc_nxt_s = acc_r;
                end else begin
                    acc_nxt_s = add_res_s;
                    ovf_nxt_s = ovf_r | add_ovf_s;
                    unf_nxt_s = unf_r | add_unf_s;
                end
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    state_nxt_s = ST_IDLE;
                    acc_nxt_s   = ACC_ZERO;
                    exc_nxt_s   = 1'b0;
                    ovf_nxt_s   = 1'b0;
                    unf_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, accumulator, flags and registered handshake outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r     <= ST_IDLE;
            acc_r       <= ACC_ZERO;
            exc_r       <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            exc_r       <= exc_nxt_s;
            ovf_r       <= ovf_nxt_s;
            unf_r       <= unf_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    // Operand capture on the input handshake.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_r     <= 32'd0;
            op_exc_r <= 1'b0;
            last_r   <= 1'b0;
        end else if ((state_r == ST_IDLE) && IN_VALID && in_ready_r) begin
            op_r     <= IN_OPERAND;
            op_exc_r <= IN_EXCEPTION;
            last_r   <= IN_LAST;
        end else begin
            op_r     <= op_r;
            op_exc_r <= op_exc_r;
            last_r   <= last_r;
        end
    end

    // Pipeline registers for the align and add stages.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            big_sign_r <= 1'b0;
            eff_sub_r  <= 1'b0;
            big_exp_r  <= 8'd0;
            big_man_r  <= 24'd0;
            small_al_r <= 24'd0;
            sum_r      <= 25'd0;
            res_sign_r <= 1'b0;
            res_exp_r  <= 8'd0;
        end else begin
            if (state_r == ST_ALIGN) begin
                big_sign_r <= big_sign_s;
                eff_sub_r  <= acc_r[31] ^ op_r[31];
                big_exp_r  <= big_exp_s;
                big_man_r  <= big_man_s;
                small_al_r <= small_al_s;
            end else begin
                big_sign_r <= big_sign_r;
                eff_sub_r  <= eff_sub_r;
                big_exp_r  <= big_exp_r;
                big_man_r  <= big_man_r;
                small_al_r <= small_al_r;
            end
            if (state_r == ST_ADD) begin
                sum_r      <= sum_s;
                res_sign_r <= big_sign_r;
                res_exp_r  <= big_exp_r;
            end else begin
                sum_r      <= sum_r;
                res_sign_r <= res_sign_r;
                res_exp_r  <= res_exp_r;
            end
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: a cycle-level expectation (ready/valid/SUM/flags)
// is kept by the driver from plain integer arithmetic on the operands, and a
// compare process checks every DUT output against it on each falling edge.
module tb_fp_accumulator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_EXCEPTION = 1'b0;
    logic        IN_LAST = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [31:0] IN_OPERAND = 32'd0;
    logic        IN_READY, OUT_VALID, EXCEPTION, OVERFLOW, UNDERFLOW;
    logic [31:0] SUM;

    int n_checks = 0;
    int n_errors = 0;
    logic        cmp_en = 1'b0;

    // Expected outputs
    logic        m_ready = 1'b1, m_valid = 1'b0;
    logic        m_exc = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [31:0] m_acc = 32'd0;

    always #5 CLK = ~CLK;

    fp_accumulator dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OPERAND(IN_OPERAND),
        .IN_EXCEPTION(IN_EXCEPTION), .IN_LAST(IN_LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM),
        .EXCEPTION(EXCEPTION), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sum of acc and op following the accumulator's arithmetic rules,
    // returned as {exception, overflow, underflow, acc}.
    function automatic logic [34:0] model_step(input logic [31:0] acc, input logic exc,
            input logic ovf, input logic unf, input logic [31:0] op, input logic op_exc);
        longint ma, mo, mb, ms, r, mant;
        int ea, eo, eb, es, d, p, e;
        logic sb, ss;
        if (op_exc || op[30:23] == 8'hFF || exc) return {1'b1, ovf, unf, 32'h7FC00000};
        if (ovf) return {exc, ovf, unf, acc};
        ea = int'(acc[30:23]);
        eo = int'(op[30:23]);
        ma = (ea == 0) ? 64'd0 : (longint'(1) << 23) + longint'(acc[22:0]);
        mo = (eo == 0) ? 64'd0 : (longint'(1) << 23) + longint'(op[22:0]);
        if (ea > eo || (ea == eo && ma >= mo)) begin
            eb = ea; mb = ma; sb = acc[31]; es = eo; ms = mo; ss = op[31];
        end else begin
            eb = eo; mb = mo; sb = op[31]; es = ea; ms = ma; ss = acc[31];
        end
        d = eb - es;
        ms = (d >= 25) ? 64'd0 : (ms >> d);
        r = (sb == ss) ? mb + ms : mb - ms;
        if (r == 0) return {exc, ovf, unf, 32'h0};
        p = 0;
        for (int i = 0; i < 26; i++) if (r[i]) p = i;
        e = eb + p - 23;
        mant = (p >= 23) ? (r >> (p - 23)) : (r << (23 - p));
        if (e >= 255) return {exc, 1'b1, unf, {sb, 8'hFF, 23'd0}};
        if (e <= 0) return {exc, ovf, 1'b1, 32'h0};
        return {exc, ovf, unf, {sb, e[7:0], mant[22:0]}};
    endfunction

    task automatic model_reset();
        m_ready = 1'b1; m_valid = 1'b0; m_acc = 32'd0;
        m_exc = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // Called 1ns after a rising edge with the DUT idle.
    task automatic send(input logic [31:0] op, input logic exc, input logic last);
        logic [34:0] nxt;
        IN_VALID = 1'b1; IN_OPERAND = op; IN_EXCEPTION = exc; IN_LAST = last;
        @(posedge CLK); #1;
        m_ready = 1'b0;
        // Junk held on a still-valid input must be ignored while busy.
        IN_OPERAND = $urandom;
        IN_EXCEPTION = 1'($urandom_range(0, 1));
        IN_LAST = 1'($urandom_range(0, 1));
        repeat (3) @(posedge CLK);
        #1;
        IN_VALID = 1'b0; IN_EXCEPTION = 1'b0; IN_LAST = 1'b0;
        nxt = model_step(m_acc, m_exc, m_ovf, m_unf, op, exc);
        {m_exc, m_ovf, m_unf, m_acc} = nxt;
        m_ready = ~last;
        m_valid = last;
    endtask

    task automatic consume(input int hold);
        IN_VALID = 1'($urandom_range(0, 1));
        IN_OPERAND = $urandom;
        repeat (hold) begin @(posedge CLK); #1; end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        IN_VALID = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic lit_result(input string name, input logic [31:0] sum, input logic [2:0] flags);
        check({name, "_sum"}, {32'd0, SUM}, {32'd0, sum});
        check({name, "_flags"}, {61'd0, EXCEPTION, OVERFLOW, UNDERFLOW}, {61'd0, flags});
        check({name, "_valid"}, {62'd0, OUT_VALID, IN_READY}, {62'd0, 2'b10});
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        int          sel;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        sel = $urandom_range(0, 9);
        case (sel)
            0: return {~m_acc[31], m_acc[30:0] ^ 31'($urandom_range(0, 7))};
            1: e = 8'($urandom_range(250, 254));
            2: e = 8'($urandom_range(0, 3));
            3: e = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(120, 134));
            default: e = 8'($urandom_range(120, 134));
        endcase
        return {s, e, f};
    endfunction

    // Every-cycle comparison of all outputs against the expectation.
    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                check("cycle", {27'd0, IN_READY, OUT_VALID, EXCEPTION, OVERFLOW, UNDERFLOW, SUM},
                      {27'd0, m_ready, m_valid, m_exc, m_ovf, m_unf, m_acc});
            end
        end
    end

    initial begin
        int n;
        #2 RESET = 1'b0;
        #1;
        check("reset_out", {27'd0, IN_READY, OUT_VALID, EXCEPTION, OVERFLOW, UNDERFLOW, SUM},
              {27'd0, 1'b1, 1'b0, 3'b000, 32'h0});
        cmp_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        idle(1);

        send(32'h40A00000, 1'b0, 1'b1);
        lit_result("single", 32'h40A00000, 3'b000);
        consume(2);

        send(32'h41C80000, 1'b0, 1'b0);
        send(32'h41C80000, 1'b0, 1'b1);
        lit_result("twentyfive_x2", 32'h42480000, 3'b000);
        consume(0);

        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h30800000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            lit_result("backpressure", 32'h3F800000, 3'b000);
            @(posedge CLK); #1;
        end
        consume(0);

        send(32'h40A00000, 1'b0, 1'b0);
        send(32'hC0A00000, 1'b0, 1'b1);
        lit_result("cancel", 32'h00000000, 3'b000);
        consume(1);

        send(32'h7F000000, 1'b0, 1'b0);
        send(32'h7F000000, 1'b0, 1'b1);
        lit_result("overflow", 32'h7F800000, 3'b010);
        consume(0);
        send(32'h3F800000, 1'b0, 1'b1);
        lit_result("ovf_cleared", 32'h3F800000, 3'b000);
        consume(0);

        send(32'h00C00000, 1'b0, 1'b0);
        send(32'h80800000, 1'b0, 1'b1);
        lit_result("underflow", 32'h00000000, 3'b001);
        consume(0);

        send(32'h40A00000, 1'b1, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        lit_result("exception", 32'h7FC00000, 3'b100);
        consume(0);

        // Reset while the accepted operand is in ADD.
        send(32'h3F800000, 1'b0, 1'b0);
        IN_VALID = 1'b1; IN_OPERAND = 32'h40000000; IN_LAST = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        m_ready = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        #1;
        check("reset_mid", {27'd0, IN_READY, OUT_VALID, EXCEPTION, OVERFLOW, UNDERFLOW, SUM},
              {27'd0, 1'b1, 1'b0, 3'b000, 32'h0});
        @(posedge CLK); #1;
        RESET = 1'b1;
        idle(1);
        send(32'h3F800000, 1'b0, 1'b1);
        lit_result("after_reset", 32'h3F800000, 3'b000);
        consume(0);

        for (int s = 0; s < 60; s++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                idle($urandom_range(0, 2));
                send(rand_op(), 1'($urandom_range(0, 29) == 0), 1'(k == n - 1));
            end
            consume($urandom_range(0, 3));
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
